// File: rtl/store_write_buffer.sv
// store_write_buffer
//   In-order store queue between the memory stage and the data RAM write port.
//   Stores are queued in a DEPTH-entry FIFO and drained one per cycle into a
//   registered RAM write port whenever the RAM is not busy. Loads are served
//   combinationally from pending stores (youngest matching address wins).
//
//   Optional build macro: STWB_COALESCE_EN
//     When defined, a store to the same address as the youngest queued entry
//     overwrites that entry's data instead of allocating a new one.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   st_valid/st_ready         store handshake; st_addr/st_data store payload
//   ld_valid/ld_addr          load probe; ld_hit/ld_data forwarded result
//   ram_busy                  RAM cannot take a write this cycle
//   ram_wren/ram_wraddress/ram_data   registered RAM write port
//   count/empty/full          occupancy status (registered state only)
module store_write_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  input  logic                       ram_busy,
  output logic                       ram_wren,
  output logic [ADDR_W-1:0]          ram_wraddress,
  output logic [DATA_W-1:0]          ram_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              ent_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q, count_d;
  logic              ram_wren_q;
  ent_t              out_q;

  logic              push, pop, alloc, coal;
  logic [PW-1:0]     idx;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign st_ready = !full;
  assign push     = st_valid && !full;
  assign pop      = !empty && !ram_busy;

`ifdef STWB_COALESCE_EN
  logic [PW-1:0] young;
  assign young = tail_q - PW'(1);
  // Merge into the youngest entry unless it is leaving via the head this edge.
  assign coal  = push && vld_q[young] && (ent_q[young].addr == st_addr) &&
                 !(pop && (young == head_q));
`else
  assign coal  = 1'b0;
`endif

  assign alloc = push && !coal;

  always_comb begin
    count_d = count_q;
    if (alloc && !pop)      count_d = count_q + CW'(1);
    else if (!alloc && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      vld_q      <= '0;
      ram_wren_q <= 1'b0;
      out_q      <= '0;
    end else begin
      count_q    <= count_d;
      ram_wren_q <= pop;
      if (pop) begin
        out_q          <= ent_q[head_q];
        vld_q[head_q]  <= 1'b0;
        head_q         <= head_q + PW'(1);
      end
      // Full blocks alloc, so tail never aliases the head being cleared.
      if (alloc) begin
        vld_q[tail_q] <= 1'b1;
        tail_q        <= tail_q + PW'(1);
      end
    end
  end

  // Payload storage needs no reset: validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    if (alloc) ent_q[tail_q] <= '{addr: st_addr, data: st_data};
`ifdef STWB_COALESCE_EN
    if (coal) ent_q[young].data <= st_data;
`endif
  end

  // Scan oldest to youngest so the last match (youngest) wins. The output
  // register is older than anything still in the FIFO.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (ram_wren_q && (out_q.addr == ld_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = out_q.data;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if (vld_q[idx] && (ent_q[idx].addr == ld_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_q[idx].data;
      end
    end
  end

  assign ld_hit        = ld_valid && fwd_hit;
  assign ld_data       = ld_hit ? fwd_data : '0;
  assign ram_wren      = ram_wren_q;
  assign ram_wraddress = out_q.addr;
  assign ram_data      = out_q.data;
  assign count         = count_q;
endmodule

// File: tb/tb_store_write_buffer.sv
// Scoreboard bench for store_write_buffer: accepted stores push the expected
// RAM write; the write monitor pops and compares in order.
module tb_store_write_buffer;
  logic        clk = 0;
  logic        rst = 1;
  logic        st_valid = 0, ld_valid = 0, ram_busy = 0;
  logic        st_ready, ld_hit, ram_wren, empty, full;
  logic [15:0] st_addr = 0, st_data = 0, ld_addr = 0;
  logic [15:0] ld_data, ram_wraddress, ram_data;
  logic [2:0]  count;

  typedef struct { logic [15:0] a; logic [15:0] d; } wr_t;
  wr_t exp_q[$];
  int  wr_cyc_q[$];
  wr_t mon_e;
  int  errs = 0, checks = 0, nwr = 0, cyc = 0;

  store_write_buffer dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .ram_busy(ram_busy), .ram_wren(ram_wren), .ram_wraddress(ram_wraddress),
    .ram_data(ram_data), .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ram_wren) begin
      nwr++;
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) chk("wr_spurious", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", ram_wraddress, mon_e.a);
        chk("wr_data", ram_data, mon_e.d);
      end
    end
  end

  task automatic do_store(input logic [15:0] a, input logic [15:0] d, output bit acc);
    st_valid = 1; st_addr = a; st_data = d;
    @(negedge clk);
    acc = st_ready;
    if (acc) begin
`ifdef STWB_COALESCE_EN
      if (ram_busy && exp_q.size() > 0 && exp_q[$].a == a) exp_q[$].d = d;
      else exp_q.push_back('{a: a, d: d});
`else
      exp_q.push_back('{a: a, d: d});
`endif
    end
    @(posedge clk); #1;
    st_valid = 0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || !empty || ram_wren) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_timeout"}, n < 100, 1);
    chk({tag, "_count0"}, count, 0);
    chk({tag, "_empty"}, empty, 1);
  endtask

  initial begin
    bit acc;
    int snap;
    #2;
    chk("rst_wren", ram_wren, 0);
    chk("rst_waddr", ram_wraddress, 0);
    chk("rst_wdata", ram_data, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ready", st_ready, 1);
    @(posedge clk); @(posedge clk); #1 rst = 0;

    // two back-to-back stores drain on consecutive cycles
    wr_cyc_q.delete();
    do_store(16'h0010, 16'hAAAA, acc); chk("t1_acc0", acc, 1);
    do_store(16'h0011, 16'hBBBB, acc); chk("t1_acc1", acc, 1);
    drain("t1");
    chk("t1_nwr", wr_cyc_q.size(), 2);
    if (wr_cyc_q.size() == 2) chk("t1_consec", wr_cyc_q[1] - wr_cyc_q[0], 1);

    // busy RAM: fill, reject fifth, then drain in order
    ram_busy = 1; @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      do_store(16'h0040 + 16'(i), 16'hC000 + 16'(i), acc);
      chk("t2_acc", acc, 1);
    end
    chk("t2_full", full, 1);
    chk("t2_count4", count, 4);
    chk("t2_ready0", st_ready, 0);
    do_store(16'h0044, 16'hC004, acc);
    chk("t2_acc5", acc, 0);
    ram_busy = 0;
    drain("t2");
    chk("t2_ready1", st_ready, 1);

    // forwarding: youngest of two same-address stores
    ram_busy = 1; @(posedge clk); #1;
    do_store(16'h0020, 16'h1111, acc);
    do_store(16'h0020, 16'h2222, acc);
    ld_valid = 1; ld_addr = 16'h0020; #1;
    chk("t3_hit", ld_hit, 1);
    chk("t3_data", ld_data, 16'h2222);
    ld_addr = 16'h0021; #1;
    chk("t3_miss_hit", ld_hit, 0);
    chk("t3_miss_data", ld_data, 0);
    ld_addr = 16'h0020; ld_valid = 0; #1;
    chk("t3_noval_hit", ld_hit, 0);
    ram_busy = 0;
    drain("t3");

    // forwarding from FIFO, then from the output register, then gone
    ld_valid = 1; ld_addr = 16'h0050;
    do_store(16'h0050, 16'h5555, acc);
    chk("t3b_fifo_hit", ld_hit, 1);
    chk("t3b_fifo_data", ld_data, 16'h5555);
    @(posedge clk); #1;
    chk("t3b_out_wren", ram_wren, 1);
    chk("t3b_out_hit", ld_hit, 1);
    chk("t3b_out_data", ld_data, 16'h5555);
    @(posedge clk); #1;
    chk("t3b_gone_hit", ld_hit, 0);
    ld_valid = 0;
    drain("t3b");

    // full with st_valid and a pop on the same edge: no push-through
    ram_busy = 1; @(posedge clk); #1;
    for (int i = 0; i < 4; i++) do_store(16'h0060 + 16'(i), 16'hD000 + 16'(i), acc);
    st_valid = 1; st_addr = 16'h0064; st_data = 16'hD004; ram_busy = 0;
    @(negedge clk);
    chk("t4_ready0", st_ready, 0);
    @(posedge clk); #1;
    chk("t4_count3", count, 3);
    @(negedge clk);
    chk("t4_ready1", st_ready, 1);
    if (st_ready) exp_q.push_back('{a: 16'h0064, d: 16'hD004});
    @(posedge clk); #1;
    st_valid = 0;
    chk("t4_count_keep", count, 3);
    drain("t4");

    // reset mid-operation discards the queue
    ram_busy = 1; @(posedge clk); #1;
    for (int i = 0; i < 4; i++) do_store(16'h0070 + 16'(i), 16'hE000 + 16'(i), acc);
    ram_busy = 0;
    @(posedge clk); #1;
    chk("t5_wren1", ram_wren, 1);
    chk("t5_count3", count, 3);
    @(negedge clk); #1;
    rst = 1; #1;
    chk("t5_rst_wren", ram_wren, 0);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_empty", empty, 1);
    exp_q.delete();
    snap = nwr;
    @(posedge clk); @(posedge clk); #1 rst = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("t5_no_writes", nwr - snap, 0);
    chk("t5_wren0", ram_wren, 0);

    // same-address pair while busy: coalesced or two entries
    ram_busy = 1; @(posedge clk); #1;
    do_store(16'h0030, 16'h0001, acc);
    do_store(16'h0030, 16'h0002, acc);
`ifdef STWB_COALESCE_EN
    chk("t6_count", count, 1);
`else
    chk("t6_count", count, 2);
`endif
    snap = nwr;
    ram_busy = 0;
    drain("t6");
`ifdef STWB_COALESCE_EN
    chk("t6_nwr", nwr - snap, 1);
`else
    chk("t6_nwr", nwr - snap, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
